// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the EX/MEM inputs, the stall handshake, the data-memory
// req/ack bus and the MEM/WB outputs of the memory-access stage.
// The slave modport is the stage itself; the master modport is its surroundings
// (upstream pipeline, data memory and writeback).
interface mem_stage_if;
  localparam int XLEN = 32;

  // EX/MEM slot
  logic            in_valid;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] rs2_data;
  logic            MemRW;
  logic            mem_en;
  logic [2:0]      RWType;
  logic            MemtoReg;
  logic            RegWriteIn;
  logic [4:0]      rd_addr_in;
  logic            stall_out;

  // data-memory bus
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_wstrb;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  // MEM/WB
  logic            wb_valid;
  logic            RegWriteOut;
  logic [4:0]      rd_addr_out;
  logic [XLEN-1:0] wb_data;
  logic            misalign;
  logic [XLEN-1:0] misalign_addr;

  modport slave (
    input  in_valid, alu_result, rs2_data, MemRW, mem_en, RWType, MemtoReg,
           RegWriteIn, rd_addr_in,
    output stall_out,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata,
    output wb_valid, RegWriteOut, rd_addr_out, wb_data, misalign, misalign_addr
  );

  modport master (
    output in_valid, alu_result, rs2_data, MemRW, mem_en, RWType, MemtoReg,
           RegWriteIn, rd_addr_in,
    input  stall_out,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata,
    input  wb_valid, RegWriteOut, rd_addr_out, wb_data, misalign, misalign_addr
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage. Accepts one instruction per cycle,
// runs byte/half/word loads and stores over a req/ack bus (lane steering,
// sign/zero extension) and holds the MEM/WB register.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// accesses skip the bus and retire at once with misalign flagged; otherwise the
// address is forced to natural alignment.
// A non-memory op accepted on the same cycle a bus access completes cannot share
// the MEM/WB edge, so it parks in a one-entry pending slot and retires on the
// following edge, keeping retirement in program order.
module mem_stage #(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic         clk,
  input  logic         reset,
  mem_stage_if.slave   io
);

  typedef enum logic {IDLE, BUS} state_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            regwrite;
`ifdef MEM_MISALIGN_TRAP_EN
    logic            trap;
`endif
  } wb_rec_t;

  state_t          state_reg, state_next;

  // access latched for the bus phase
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] res_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [3:0]      wstrb_reg;
  logic            we_reg;
  logic [1:0]      size_reg;
  logic [1:0]      off_reg;
  logic            unsigned_reg;
  logic            memtoreg_reg;
  logic            regwrite_reg;
  logic [4:0]      rd_reg;

  // MEM/WB and pending slot
  logic            wb_valid_reg;
  wb_rec_t         wb_reg;
  logic            pend_valid_reg;
  wb_rec_t         pend_reg;

  // input decode
  logic [1:0]      size_in;   // 0 byte, 1 half, 2 word
  logic [1:0]      off_in;    // naturally aligned byte offset
  logic [XLEN-1:0] wdata_in;
  logic [3:0]      wstrb_in;
  logic            trap_in;

  logic            stall;
  logic            accept;
  logic            go_bus;
  logic            direct_go;
  logic            bus_done;

  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] load_ext;
  wb_rec_t         direct_rec;
  wb_rec_t         bus_rec;

  assign bus_done  = (state_reg == BUS) && io.dmem_ack;
  assign stall     = (state_reg == BUS) && !io.dmem_ack;
  assign accept    = io.in_valid && !stall;
  assign go_bus    = accept && io.mem_en && !trap_in;
  assign direct_go = accept && !go_bus;

  // Decode access size, aligned lane offset, steered store data and strobes.
  always_comb begin
    size_in = 2'd2;
    off_in  = 2'b00;
    case (io.RWType)
      3'b000, 3'b100: size_in = 2'd0;
      3'b001, 3'b101: size_in = 2'd1;
      default:        size_in = 2'd2;
    endcase
    case (size_in)
      2'd0:    off_in = io.alu_result[1:0];
      2'd1:    off_in = {io.alu_result[1], 1'b0};
      default: off_in = 2'b00;
    endcase
    case (size_in)
      2'd0: begin
        wdata_in = {4{io.rs2_data[7:0]}};
        wstrb_in = 4'b0001 << off_in;
      end
      2'd1: begin
        wdata_in = {2{io.rs2_data[15:0]}};
        wstrb_in = 4'b0011 << off_in;
      end
      default: begin
        wdata_in = io.rs2_data;
        wstrb_in = 4'b1111;
      end
    endcase
    if (!io.MemRW) wstrb_in = 4'b0000;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Misaligned exactly when natural alignment would move the address.
  assign trap_in = io.mem_en && (off_in != io.alu_result[1:0]);
`else
  assign trap_in = 1'b0;
`endif

  // Extract the addressed lane of the read word and extend it.
  always_comb begin
    case (off_reg)
      2'd0:    lane_b = io.dmem_rdata[7:0];
      2'd1:    lane_b = io.dmem_rdata[15:8];
      2'd2:    lane_b = io.dmem_rdata[23:16];
      default: lane_b = io.dmem_rdata[31:24];
    endcase
    lane_h = off_reg[1] ? io.dmem_rdata[31:16] : io.dmem_rdata[15:0];
    case (size_reg)
      2'd0:    load_ext = unsigned_reg ? {{(XLEN-8){1'b0}}, lane_b}
                                       : {{(XLEN-8){lane_b[7]}}, lane_b};
      2'd1:    load_ext = unsigned_reg ? {{(XLEN-16){1'b0}}, lane_h}
                                       : {{(XLEN-16){lane_h[15]}}, lane_h};
      default: load_ext = io.dmem_rdata;
    endcase
  end

  // Build the retirement records for a direct (1-cycle) op and a bus completion.
  always_comb begin
    direct_rec    = '0;
    direct_rec.rd = io.rd_addr_in;
    if (trap_in) begin
      direct_rec.data     = io.alu_result;
      direct_rec.regwrite = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      direct_rec.trap     = 1'b1;
`endif
    end else begin
      direct_rec.data     = io.MemtoReg ? '0 : io.alu_result;
      direct_rec.regwrite = io.RegWriteIn;
    end
    bus_rec          = '0;
    bus_rec.data     = memtoreg_reg ? load_ext : res_reg;
    bus_rec.rd       = rd_reg;
    bus_rec.regwrite = regwrite_reg;
  end

  // Next-state: enter BUS on a memory accept, leave on ack unless re-entering.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (go_bus) state_next = BUS;
      BUS:     if (io.dmem_ack) state_next = go_bus ? BUS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Latch the access on accept so every bus output comes from a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg     <= '0;
      res_reg      <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= 4'b0000;
      we_reg       <= 1'b0;
      size_reg     <= 2'd0;
      off_reg      <= 2'd0;
      unsigned_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      regwrite_reg <= 1'b0;
      rd_reg       <= 5'd0;
    end else if (go_bus) begin
      addr_reg     <= {io.alu_result[XLEN-1:2], 2'b00};
      res_reg      <= io.alu_result;
      wdata_reg    <= wdata_in;
      wstrb_reg    <= wstrb_in;
      we_reg       <= io.MemRW;
      size_reg     <= size_in;
      off_reg      <= off_in;
      unsigned_reg <= io.RWType[2];
      memtoreg_reg <= io.MemtoReg;
      regwrite_reg <= io.RegWriteIn;
      rd_reg       <= io.rd_addr_in;
    end
  end

  // MEM/WB update in program order: pending, then bus completion, then direct.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_reg   <= 1'b0;
      wb_reg         <= '0;
      pend_valid_reg <= 1'b0;
      pend_reg       <= '0;
    end else begin
      if (pend_valid_reg) begin
        wb_valid_reg   <= 1'b1;
        wb_reg         <= pend_reg;
        pend_valid_reg <= direct_go;
      end else if (bus_done) begin
        wb_valid_reg   <= 1'b1;
        wb_reg         <= bus_rec;
        pend_valid_reg <= direct_go;
      end else if (direct_go) begin
        wb_valid_reg   <= 1'b1;
        wb_reg         <= direct_rec;
      end else begin
        wb_valid_reg   <= 1'b0;
      end
      if (direct_go) pend_reg <= direct_rec;
    end
  end

  assign io.stall_out   = stall;
  assign io.dmem_req    = (state_reg == BUS);
  assign io.dmem_we     = (state_reg == BUS) && we_reg;
  assign io.dmem_addr   = addr_reg;
  assign io.dmem_wdata  = wdata_reg;
  assign io.dmem_wstrb  = wstrb_reg;
  assign io.wb_valid    = wb_valid_reg;
  assign io.RegWriteOut = wb_valid_reg && wb_reg.regwrite;
  assign io.rd_addr_out = wb_reg.rd;
  assign io.wb_data     = wb_reg.data;

`ifdef MEM_MISALIGN_TRAP_EN
  assign io.misalign      = wb_valid_reg && wb_reg.trap;
  assign io.misalign_addr = (wb_valid_reg && wb_reg.trap) ? wb_reg.data : '0;
`else
  assign io.misalign      = 1'b0;
  assign io.misalign_addr = '0;
`endif

endmodule
